// File: rtl/argmax_chunk_streamer_if.sv
// Handshake/bus bundle between the argmax chunk streamer and its controller/consumer.
// master drives start/hold/data_in; slave (the streamer) drives ready and the result strobe.
interface argmax_chunk_streamer_if #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned CHUNK_SIZE      = 16,
  parameter int unsigned NUM_CHUNKS      = 4,
  parameter int unsigned IN_ARGMAX_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH     = 2
);
  logic                                     start;
  logic                                     hold;
  logic [NUM_CHUNKS*CHUNK_SIZE*WIDTH-1:0]   data_in;
  logic                                     ready;
  logic                                     out_valid;
  logic signed [WIDTH-1:0]                  out_value;
  logic [IN_ARGMAX_WIDTH-1:0]               out_index;
  logic [COUNT_WIDTH-1:0]                   out_chunk;
  logic                                     done;

  modport master (
    output start, hold, data_in,
    input  ready, out_valid, out_value, out_index, out_chunk, done
  );

  modport slave (
    input  start, hold, data_in,
    output ready, out_valid, out_value, out_index, out_chunk, done
  );
endinterface

// File: rtl/argmax_chunk_streamer.sv
// Captures a wide signed vector and emits one chunk argmax (value, local index, chunk) per cycle.
// Optional macro ARGMAX_TIE_LAST_EN: ties resolve to the highest lane instead of the lowest.
module argmax_chunk_streamer #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned CHUNK_SIZE      = 16,
  parameter int unsigned NUM_CHUNKS      = 4,
  parameter int unsigned IN_ARGMAX_WIDTH = 4,
  parameter int unsigned COUNT_WIDTH     = 2
) (
  input logic                    clk,
  input logic                    rst,
  argmax_chunk_streamer_if.slave bus
);
  localparam int unsigned ChunkBits = CHUNK_SIZE * WIDTH;
  localparam int unsigned VecBits   = NUM_CHUNKS * ChunkBits;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [VecBits-1:0]         data_q, data_d;
  logic                       ready_q, ready_d;
  logic                       valid_q, valid_d;
  logic signed [WIDTH-1:0]    value_q, value_d;
  logic [IN_ARGMAX_WIDTH-1:0] index_q, index_d;
  logic [COUNT_WIDTH-1:0]     chunk_q, chunk_d;
  logic                       done_q, done_d;

  logic [ChunkBits-1:0]       chunk_sel;
  logic signed [WIDTH-1:0]    lane_val;
  logic signed [WIDTH-1:0]    best_val;
  logic [IN_ARGMAX_WIDTH-1:0] best_idx;

  always_comb begin
    chunk_sel = data_q[ChunkBits-1:0];
    for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
      if (cnt_q == COUNT_WIDTH'(c)) begin
        chunk_sel = data_q[c*ChunkBits +: ChunkBits];
      end
    end
  end

  // Linear scan; the comparison operator alone decides which tied lane survives.
  always_comb begin
    best_val = chunk_sel[WIDTH-1:0];
    best_idx = '0;
    lane_val = '0;
    for (int unsigned l = 1; l < CHUNK_SIZE; l++) begin
      lane_val = chunk_sel[l*WIDTH +: WIDTH];
`ifdef ARGMAX_TIE_LAST_EN
      if (lane_val >= best_val) begin
`else
      if (lane_val > best_val) begin
`endif
        best_val = lane_val;
        best_idx = IN_ARGMAX_WIDTH'(l);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ready_d = ready_q;
    valid_d = valid_q;
    value_d = value_q;
    index_d = index_q;
    chunk_d = chunk_q;
    done_d  = done_q;
    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (bus.start) begin
          data_d  = bus.data_in;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (bus.hold) begin
          valid_d = 1'b0;
        end else begin
          value_d = best_val;
          index_d = best_idx;
          chunk_d = cnt_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == COUNT_WIDTH'(NUM_CHUNKS - 1)) begin
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      value_q <= '0;
      index_q <= '0;
      chunk_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      value_q <= value_d;
      index_q <= index_d;
      chunk_q <= chunk_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_value = value_q;
  assign bus.out_index = index_q;
  assign bus.out_chunk = chunk_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_argmax_chunk_streamer.sv
// Scoreboard bench for argmax_chunk_streamer: randomized vectors, holds, ignored starts and reset.
module tb_argmax_chunk_streamer;
  localparam int W   = 8;
  localparam int CS  = 16;
  localparam int NC  = 4;
  localparam int IAW = 4;
  localparam int CW  = 2;
  localparam int VB  = NC * CS * W;
`ifdef ARGMAX_TIE_LAST_EN
  localparam bit TieLast = 1'b1;
`else
  localparam bit TieLast = 1'b0;
`endif

  typedef struct {int value; int index; int chunk;} exp_t;
  typedef struct {int value; int index;} glob_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t  exp_q[$];
  glob_t glob_q[$];

  argmax_chunk_streamer_if #(
    .WIDTH(W), .CHUNK_SIZE(CS), .NUM_CHUNKS(NC), .IN_ARGMAX_WIDTH(IAW), .COUNT_WIDTH(CW)
  ) bus ();

  argmax_chunk_streamer #(
    .WIDTH(W), .CHUNK_SIZE(CS), .NUM_CHUNKS(NC), .IN_ARGMAX_WIDTH(IAW), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Index of mx within chunk c under the tie rule (first or last occurrence).
  function automatic int lane_of(input int vals[NC*CS], input int c, input int mx);
    int idx = -1;
    for (int l = 0; l < CS; l++) begin
      if (vals[c*CS+l] == mx && (idx < 0 || TieLast)) idx = l;
    end
    return idx;
  endfunction

  function automatic void push_expected(input logic [VB-1:0] v);
    int vals[NC*CS];
    int mx, gmx, gc;
    logic signed [W-1:0] t;
    for (int i = 0; i < NC*CS; i++) begin
      t = v[i*W +: W];
      vals[i] = t;
    end
    gmx = vals[0];
    foreach (vals[i]) if (vals[i] > gmx) gmx = vals[i];
    gc = -1;
    for (int c = 0; c < NC; c++) begin
      mx = vals[c*CS];
      for (int l = 0; l < CS; l++) if (vals[c*CS+l] > mx) mx = vals[c*CS+l];
      exp_q.push_back('{mx, lane_of(vals, c, mx), c});
      if (gc < 0 && mx == gmx) gc = c;
    end
    // A downstream strict-greater accumulator keeps the earliest chunk holding the max.
    glob_q.push_back('{gmx, lane_of(vals, gc, gmx) + gc*CS});
  endfunction

  function automatic logic [VB-1:0] rand_vec(input bit ties);
    logic [VB-1:0] v;
    for (int i = 0; i < NC*CS; i++) begin
      v[i*W +: W] = ties ? W'($urandom_range(0, 3)) : W'($urandom());
    end
    return v;
  endfunction

  // Monitor: pops expected chunks and models the downstream serial accumulator.
  int acc_val;
  int acc_idx;
  bit acc_any = 1'b0;
  always @(negedge clk) begin
    exp_t  e;
    glob_t g;
    int    v;
    int    gi;
    if (rst) begin
      acc_any = 1'b0;
    end else begin
      if (bus.out_valid && bus.done) check("valid_and_done_together", 1, 0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_chunk", 1, 0);
        end else begin
          e = exp_q.pop_front();
          v = int'($signed(bus.out_value));
          check("out_value", v, e.value);
          check("out_index", int'(bus.out_index), e.index);
          check("out_chunk", int'(bus.out_chunk), e.chunk);
          gi = int'(bus.out_index) + int'(bus.out_chunk) * CS;
          if (!acc_any || v > acc_val) begin
            acc_val = v;
            acc_idx = gi;
            acc_any = 1'b1;
          end
        end
      end
      if (bus.done) begin
        check("done_after_all_chunks", exp_q.size(), 0);
        if (glob_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          g = glob_q.pop_front();
          check("acc_max", acc_val, g.value);
          check("acc_argmax", acc_idx, g.index);
        end
        acc_any = 1'b0;
      end
    end
  end

  // Entered just after an edge with the DUT idle; leaves just after the done edge.
  // hold_mode: 0 none, 1 random, 2 two cycles right after chunk 1. rst_at: chunks before reset.
  task automatic run_vector(input logic [VB-1:0] v, input int hold_mode, input int rst_at);
    int emitted = 0;
    int held    = 0;
    int cyc     = 0;
    bit h;
    check("ready_before_start", int'(bus.ready), 1);
    bus.data_in = v;
    bus.start   = 1'b1;
    bus.hold    = 1'b0;
    @(posedge clk); #1;
    push_expected(v);
    bus.start = 1'b0;
    check("ready_low_after_start", int'(bus.ready), 0);
    check("valid_low_after_start", int'(bus.out_valid), 0);
    while (emitted < NC) begin
      case (hold_mode)
        1:       h = ($urandom_range(0, 2) == 0);
        2:       h = (emitted == 2 && held < 2);
        default: h = 1'b0;
      endcase
      if (h) held++;
      bus.hold    = h;
      bus.data_in = rand_vec(1'b0);
      bus.start   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!h) emitted++;
      check("valid_vs_hold", int'(bus.out_valid), int'(!h));
      check("ready_low_streaming", int'(bus.ready), 0);
      if (rst_at >= 0 && emitted == rst_at && !h) begin
        #2 rst = 1'b1;
        #1;
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_ready", int'(bus.ready), 1);
        check("rst_chunk", int'(bus.out_chunk), 0);
        exp_q.delete();
        glob_q.delete();
        bus.hold  = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("no_done_after_rst", int'(bus.done), 0);
        return;
      end
      if (++cyc > 64) begin
        check("stream_timeout", 0, 1);
        return;
      end
    end
    bus.hold    = 1'($urandom_range(0, 1));
    bus.start   = 1'b1;
    bus.data_in = rand_vec(1'b0);
    @(posedge clk); #1;
    check("done_pulse", int'(bus.done), 1);
    check("ready_with_done", int'(bus.ready), 1);
    check("valid_low_finish", int'(bus.out_valid), 0);
    bus.start = 1'b0;
    bus.hold  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_one_cycle", int'(bus.done), 0);
    check("ready_idle", int'(bus.ready), 1);
  endtask

  initial begin
    logic [VB-1:0] v;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.hold    = 1'b0;
    bus.data_in = '0;
    #12;
    check("reset_ready", int'(bus.ready), 1);
    check("reset_valid", int'(bus.out_valid), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_value", int'(bus.out_value), 0);
    check("reset_index", int'(bus.out_index), 0);
    check("reset_chunk", int'(bus.out_chunk), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Chunk maxima 5@3, -2@0, 127@15, 9@7 over a -100 background.
    v = {(NC*CS){8'h9C}};
    v[(0*CS+3)*W  +: W] = 8'h05;
    v[(1*CS+0)*W  +: W] = 8'hFE;
    v[(2*CS+15)*W +: W] = 8'h7F;
    v[(3*CS+7)*W  +: W] = 8'h09;
    run_vector(v, 0, -1);
    idle_cycle();

    // All lanes -128, started on the cycle right after the previous done.
    run_vector(v, 0, -1);
    v = {(NC*CS){8'h80}};
    run_vector(v, 0, -1);
    idle_cycle();

    // Global maximum 100 at lane 37, two-cycle hold after chunk 1.
    v = rand_vec(1'b1);
    v[37*W +: W] = 8'd100;
    run_vector(v, 2, -1);
    idle_cycle();

    // Reset while chunk 2 is on the output, then a fresh vector from chunk 0.
    run_vector(rand_vec(1'b0), 0, 3);
    run_vector(rand_vec(1'b0), 1, -1);
    idle_cycle();

    for (int n = 0; n < 24; n++) begin
      run_vector(rand_vec(1'($urandom_range(0, 1))), $urandom_range(0, 2), -1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    check("scoreboard_drained", exp_q.size() + glob_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
